// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared encodings for the intersection phase scheduler: light commands,
// scheduler states and phase indices.
package signal_pkg;

  localparam int NUM_PHASES = 3;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_GO   = 2'd1,
    ST_YEL  = 2'd2,
    ST_CLR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    L12_RED    = 2'd0,
    L12_YELLOW = 2'd1,
    L12_GO     = 2'd2
  } l12_cmd_e;

  typedef enum logic [2:0] {
    L3_RED        = 3'd0,
    L3_YELLOW     = 3'd1,
    L3_GREEN      = 3'd2,
    L3_LEFT       = 3'd3,
    L3_GREEN_LEFT = 3'd4
  } l3_cmd_e;

  localparam logic [1:0] PH_L1 = 2'd0;
  localparam logic [1:0] PH_L2 = 2'd1;
  localparam logic [1:0] PH_L3 = 2'd2;

  // Round-robin successor over the three phases.
  function automatic logic [1:0] next_phase_of(input logic [1:0] p);
    return (p == PH_L3) ? PH_L1 : p + 2'd1;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Saturating state timer with synchronous clear and a terminal compare
// against a limit chosen by the scheduler for the current state.
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  // ">=" rather than "==" so a GO held past its nominal time still releases.
  assign at_limit = (count >= limit);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven three-phase intersection sequencer with demand latching,
// phase skipping, fixed yellow/all-red clearance and emergency preemption.
module intersection_phase_scheduler
  import signal_pkg::*;
#(
  parameter int GO_TIME  = 20,
  parameter int YEL_TIME = 3,
  parameter int CLR_TIME = 2,
  parameter int INIT_RED = 4,
  parameter int MIN_GO   = 5,
  parameter int SKIP_EN  = 1,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] demand,
  input  logic       emg_req,
  input  logic [1:0] emg_phase,
  output logic [1:0] L1_cmd,
  output logic [1:0] L2_cmd,
  output logic [2:0] L3_cmd,
  output logic [1:0] cur_phase,
  output logic [1:0] cur_state,
  output logic       emg_active
);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       dem_q, dem_d;
  logic [1:0]       sel_phase;
  logic [CNT_W-1:0] timer, limit;
  logic             at_limit, timer_clear;
  logic             emg_valid, hold, truncate, enter_go;
  logic [1:0]       l1_d, l2_d;
  logic [2:0]       l3_d;
  logic             emg_d;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (timer_clear),
    .enable   (1'b1),
    .limit    (limit),
    .count    (timer),
    .at_limit (at_limit)
  );

  assign emg_valid = emg_req && (emg_phase != 2'd3);
  assign hold      = (state_q == ST_GO) && emg_valid && (emg_phase == phase_q);
  assign truncate  = (state_q == ST_GO) && emg_valid && (emg_phase != phase_q) &&
                     (timer >= CNT_W'(MIN_GO - 1));

  always_comb begin
    limit = CNT_W'(INIT_RED - 1);
    case (state_q)
      ST_GO:   limit = CNT_W'(GO_TIME - 1);
      ST_YEL:  limit = CNT_W'(YEL_TIME - 1);
      ST_CLR:  limit = CNT_W'(CLR_TIME - 1);
      default: limit = CNT_W'(INIT_RED - 1);
    endcase
  end

  // Next phase: emergency first, then latched demand searched from the
  // phase after the current one (current phase last), else plain recall.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    sel_phase = next_phase_of(phase_q);
    cand      = phase_q;
    found     = 1'b0;
    if (emg_valid) begin
      sel_phase = emg_phase;
    end else if ((SKIP_EN != 0) && (dem_q != 3'b000)) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        cand = next_phase_of(cand);
        if (!found && dem_q[cand]) begin
          sel_phase = cand;
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_INIT: begin
        if (at_limit) begin
          state_d = ST_GO;
          phase_d = sel_phase;
        end
      end
      ST_GO: begin
        if (!hold && (truncate || at_limit)) state_d = ST_YEL;
      end
      ST_YEL: begin
        if (at_limit) state_d = ST_CLR;
      end
      ST_CLR: begin
        if (at_limit) begin
          state_d = ST_GO;
          phase_d = sel_phase;
        end
      end
      default: state_d = ST_INIT;
    endcase
    timer_clear = (state_d != state_q);
    enter_go    = (state_q != ST_GO) && (state_d == ST_GO);
  end

  // The clear of the phase being served overrides a same-cycle request.
  always_comb begin
    dem_d = dem_q | demand;
    if (enter_go) dem_d = dem_d & ~(3'b001 << phase_d);
  end

  always_comb begin
    l1_d  = L12_RED;
    l2_d  = L12_RED;
    l3_d  = L3_RED;
    emg_d = 1'b0;
    if (state_d == ST_GO) begin
      case (phase_d)
        PH_L1:   l1_d = L12_GO;
        PH_L2:   l2_d = L12_GO;
        default: l3_d = L3_GREEN_LEFT;
      endcase
      emg_d = emg_valid && (emg_phase == phase_d);
    end else if (state_d == ST_YEL) begin
      case (phase_d)
        PH_L1:   l1_d = L12_YELLOW;
        PH_L2:   l2_d = L12_YELLOW;
        default: l3_d = L3_YELLOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      phase_q    <= PH_L3;
      dem_q      <= 3'b000;
      L1_cmd     <= L12_RED;
      L2_cmd     <= L12_RED;
      L3_cmd     <= L3_RED;
      emg_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      dem_q      <= dem_d;
      L1_cmd     <= l1_d;
      L2_cmd     <= l2_d;
      L3_cmd     <= l3_d;
      emg_active <= emg_d;
    end
  end

  assign cur_state = state_q;
  assign cur_phase = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench: tabulated reset-release sequence, hand-written corner
// sequences and a randomized run against a time-based reference model.
module tb_intersection_phase_scheduler;

  localparam int GO_TIME  = 20;
  localparam int YEL_TIME = 3;
  localparam int CLR_TIME = 2;
  localparam int INIT_RED = 4;
  localparam int MIN_GO   = 5;
  localparam int S_INIT = 0, S_GO = 1, S_YEL = 2, S_CLR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] demand = 3'b000;
  logic       emg_req = 1'b0;
  logic [1:0] emg_phase = 2'd0;
  logic [1:0] L1_cmd, L2_cmd, cur_phase, cur_state;
  logic [2:0] L3_cmd;
  logic       emg_active;

  intersection_phase_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .demand     (demand),
    .emg_req    (emg_req),
    .emg_phase  (emg_phase),
    .L1_cmd     (L1_cmd),
    .L2_cmd     (L2_cmd),
    .L3_cmd     (L3_cmd),
    .cur_phase  (cur_phase),
    .cur_state  (cur_state),
    .emg_active (emg_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: which phase owns the road, what it is doing, and how
  // many whole seconds it has been doing it.
  int       m_state, m_phase, m_elapsed;
  bit [2:0] m_dem;
  bit       m_emg;

  typedef struct {
    logic [2:0] demand;
    logic       emg_req;
    logic [1:0] emg_phase;
    int         cycle;
    int         l1, l2, l3, state, phase;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(int c, int l1, int l2, int l3, int st, int ph);
    vec_t v;
    v.demand = 3'b000; v.emg_req = 1'b0; v.emg_phase = 2'd0;
    v.cycle = c; v.l1 = l1; v.l2 = l2; v.l3 = l3; v.state = st; v.phase = ph;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic int expCmd(int light);
    if (m_phase != light) return 0;
    if (m_state == S_GO) return (light == 2) ? 4 : 2;
    if (m_state == S_YEL) return 1;
    return 0;
  endfunction

  function automatic int pickPhase(bit ev);
    if (ev) return int'(emg_phase);
    for (int k = 1; k <= 3; k++) begin
      if (m_dem[(m_phase + k) % 3]) return (m_phase + k) % 3;
    end
    return (m_phase + 1) % 3;
  endfunction

  task automatic modelReset();
    m_state = S_INIT; m_phase = 2; m_elapsed = 0; m_dem = 3'b000; m_emg = 1'b0;
  endtask

  task automatic modelStep();
    bit ev, enter;
    int ns, np, dur;
    ev    = emg_req && (emg_phase <= 2'd2);
    ns    = m_state;
    np    = m_phase;
    enter = 1'b0;
    dur   = m_elapsed + 1;
    case (m_state)
      S_INIT: enter = (dur >= INIT_RED);
      S_GO: begin
        if (!(ev && int'(emg_phase) == m_phase)) begin
          if ((ev && dur >= MIN_GO) || dur >= GO_TIME) ns = S_YEL;
        end
      end
      S_YEL: if (dur >= YEL_TIME) ns = S_CLR;
      default: enter = (dur >= CLR_TIME);
    endcase
    if (enter) begin
      ns = S_GO;
      np = pickPhase(ev);
    end
    m_dem = m_dem | demand;
    if (enter) m_dem[np] = 1'b0;
    m_elapsed = (ns != m_state) ? 0 : dur;
    m_state   = ns;
    m_phase   = np;
    m_emg     = (ns == S_GO) && ev && (int'(emg_phase) == np);
  endtask

  task automatic checkOutput();
    checkValue("L1_cmd", L1_cmd, expCmd(0));
    checkValue("L2_cmd", L2_cmd, expCmd(1));
    checkValue("L3_cmd", L3_cmd, expCmd(2));
    checkValue("cur_state", cur_state, m_state);
    checkValue("cur_phase", cur_phase, m_phase);
    checkValue("emg_active", emg_active, m_emg);
    checkValue("dem_q", dut.dem_q, m_dem);
  endtask

  task automatic applyStimulus(input logic [2:0] d, input logic er, input logic [1:0] ep);
    demand = d; emg_req = er; emg_phase = ep;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic runTo(input int n);
    while (cyc < n) tick();
  endtask

  // Reset is asserted away from any clock edge so its effect is purely asynchronous.
  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput();
    repeat (2) @(posedge clk);
    #2;
    applyStimulus(3'b000, 1'b0, 2'd0);
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int held;
    #1;

    // Reset release with no demand: defaults cycle through phase 0 then 1.
    vecs.push_back(mkVec(0,  0, 0, 0, S_INIT, 2));
    vecs.push_back(mkVec(3,  0, 0, 0, S_INIT, 2));
    vecs.push_back(mkVec(4,  2, 0, 0, S_GO,   0));
    vecs.push_back(mkVec(23, 2, 0, 0, S_GO,   0));
    vecs.push_back(mkVec(24, 1, 0, 0, S_YEL,  0));
    vecs.push_back(mkVec(26, 1, 0, 0, S_YEL,  0));
    vecs.push_back(mkVec(27, 0, 0, 0, S_CLR,  0));
    vecs.push_back(mkVec(28, 0, 0, 0, S_CLR,  0));
    vecs.push_back(mkVec(29, 0, 2, 0, S_GO,   1));
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].demand, vecs[i].emg_req, vecs[i].emg_phase);
      runTo(vecs[i].cycle);
      checkValue("tbl_L1", L1_cmd, vecs[i].l1);
      checkValue("tbl_L2", L2_cmd, vecs[i].l2);
      checkValue("tbl_L3", L3_cmd, vecs[i].l3);
      checkValue("tbl_state", cur_state, vecs[i].state);
      checkValue("tbl_phase", cur_phase, vecs[i].phase);
    end

    // Skip: only phase 2 requested, so it is served first; recall follows.
    doReset();
    tick();
    applyStimulus(3'b100, 1'b0, 2'd0);
    tick();
    applyStimulus(3'b000, 1'b0, 2'd0);
    runTo(4);
    checkValue("skip_L3", L3_cmd, 4);
    checkValue("skip_L1", L1_cmd, 0);
    checkValue("skip_L2", L2_cmd, 0);
    runTo(29);
    checkValue("skip_recall_phase", cur_phase, 0);
    checkValue("skip_recall_L1", L1_cmd, 2);

    // Preemption of phase 0 by phase 2, then a 40 cycle emergency hold.
    doReset();
    runTo(6);
    applyStimulus(3'b000, 1'b1, 2'd2);
    runTo(8);
    checkValue("pre_mingo_L1", L1_cmd, 2);
    tick();
    checkValue("pre_trunc_L1", L1_cmd, 1);
    runTo(14);
    checkValue("pre_go_L3", L3_cmd, 4);
    held = 0;
    while (cyc < 54) begin
      if (emg_active === 1'b1 && L3_cmd === 3'd4) held++;
      tick();
    end
    checkValue("pre_hold_cycles", held, 40);
    applyStimulus(3'b000, 1'b0, 2'd0);
    tick();
    checkValue("pre_release_L3", L3_cmd, 1);
    checkValue("pre_release_emg", emg_active, 0);

    // Asynchronous reset while phase 1 is yellow.
    doReset();
    runTo(50);
    checkValue("rst_mid_yel_L2", L2_cmd, 1);
    #2;
    doReset();
    checkValue("rst_async_L2", L2_cmd, 0);
    runTo(3);
    checkValue("rst_init_state", cur_state, S_INIT);
    tick();
    checkValue("rst_first_phase", cur_phase, 0);

    // Request for phase 1 on the very edge it enters GO is absorbed.
    doReset();
    runTo(28);
    applyStimulus(3'b010, 1'b0, 2'd0);
    tick();
    applyStimulus(3'b000, 1'b0, 2'd0);
    checkValue("setclr_L2", L2_cmd, 2);
    checkValue("setclr_dem_q", dut.dem_q, 0);
    runTo(54);
    checkValue("setclr_next_phase", cur_phase, 2);

    // Invalid emergency phase is ignored entirely.
    doReset();
    runTo(4);
    applyStimulus(3'b000, 1'b1, 2'd3);
    runTo(23);
    checkValue("inv_go_state", cur_state, S_GO);
    checkValue("inv_emg", emg_active, 0);
    tick();
    checkValue("inv_yel_state", cur_state, S_YEL);
    applyStimulus(3'b000, 1'b0, 2'd0);

    // Randomized traffic with emergencies and one mid-run reset.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] d;
      logic       er;
      logic [1:0] ep;
      d  = 3'b000;
      for (int b = 0; b < 3; b++) d[b] = ($urandom_range(0, 7) == 0);
      er = emg_req;
      ep = emg_phase;
      if ($urandom_range(0, 24) == 0) er = ~er;
      if ($urandom_range(0, 19) == 0) ep = 2'($urandom_range(0, 3));
      applyStimulus(d, er, ep);
      if (i == 750) begin
        #2;
        doReset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
